// File: rtl/ddr2_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_out_pkg
// Description : Shared types and constants for the DDR2 read-return path.
//               Provides the collector FSM state encoding, packing constants,
//               the buffered beat record {last, data} and a helper that turns
//               a read size in words into the number of 128-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr2_out_pkg;

  localparam int WORDS_PER_BEAT = 4;
  localparam int MAX_WORDS      = 127;
  localparam int BEAT_DATA_W    = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  typedef struct packed {
    logic                   last;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  // ceil(size / 4); a 127-word read needs 32 beats, hence 6 result bits.
  function automatic logic [5:0] beats_for_size(input logic [6:0] size);
    logic [7:0] rounded;
    rounded = {1'b0, size} + 8'd3;
    return rounded[7:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_out_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_out_sync_fifo
// Description : Single-clock show-ahead FIFO with occupancy count. The head
//               entry is visible on rd_data whenever count is non-zero.
//               Writes while full and reads while empty are ignored.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               wr_en, wr_data - push request and entry
//               rd_en          - pop the head entry
//               rd_data        - head entry (show-ahead)
//               count          - number of stored entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_out_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8    // power of 2, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

endmodule
`default_nettype wire

// File: rtl/ddr2_ctrl_output.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_ctrl_output
// Description : DDR2 read-return path. Queues read-size descriptors, packs
//               32-bit read words MSB-first into 128-bit beats (first word in
//               [127:96]), buffers the beats and presents them to the UM with
//               valid/ready/last. read_permit is withheld whenever one more
//               worst-case read could overflow the beat buffer.
// Ports       : ddr2_clk, sys_rst              - clock, sync active-high reset
//               local_rdata, local_rdata_valid - DDR2 read words
//               rd_ddr2_size, rd_ddr2_size_wrreq - read descriptors
//               read_permit                    - input controller may issue
//               ddr2um_data/last/valid/ready   - UM beat stream
//               ddr2_out_err                   - sticky protocol error
//               stat_beats, stat_reads         - only with the macro below
// Options     : DDR2_CTRL_OUTPUT_STATS_EN adds UM beat/read counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_ctrl_output
  import ddr2_out_pkg::*;
#(
  parameter int OUT_DEPTH  = 64,
  parameter int SIZE_DEPTH = 8,
  parameter int MAX_BEATS  = 32
) (
  input  logic         ddr2_clk,
  input  logic         sys_rst,
  input  logic [31:0]  local_rdata,
  input  logic         local_rdata_valid,
  input  logic [6:0]   rd_ddr2_size,
  input  logic         rd_ddr2_size_wrreq,
  output logic         read_permit,
  output logic [127:0] ddr2um_data,
  output logic         ddr2um_last,
  output logic         ddr2um_valid,
  input  logic         ddr2um_ready,
  output logic         ddr2_out_err
`ifdef DDR2_CTRL_OUTPUT_STATS_EN
  ,
  output logic [31:0]  stat_beats,
  output logic [31:0]  stat_reads
`endif
);

  localparam int SC_W  = $clog2(SIZE_DEPTH) + 1;
  localparam int BC_W  = $clog2(OUT_DEPTH) + 1;
  localparam int RES_W = $clog2(OUT_DEPTH) + 2;

  // ---------------------------------------------------------------- size FIFO
  logic [6:0]      size_head;
  logic [SC_W-1:0] size_count;
  logic            size_full;
  logic            size_pop;
  logic            size_push;

  assign size_full = (size_count == SC_W'(SIZE_DEPTH));
  assign size_push = rd_ddr2_size_wrreq && !size_full;

  ddr2_out_sync_fifo #(
    .WIDTH (7),
    .DEPTH (SIZE_DEPTH)
  ) u_size_fifo (
    .clk     (ddr2_clk),
    .rst     (sys_rst),
    .wr_en   (rd_ddr2_size_wrreq),
    .wr_data (rd_ddr2_size),
    .rd_en   (size_pop),
    .rd_data (size_head),
    .count   (size_count)
  );

  // ---------------------------------------------------------------- collector
  state_t       state;
  state_t       next_state;
  logic         word_take;
  logic [6:0]   size_q;
  logic [6:0]   words_left;
  logic [1:0]   lane;
  logic [127:0] asm_data;
  logic [127:0] asm_next;
  logic         pend_valid;
  beat_t        pend_beat;
  logic         beat_done;

  always_ff @(posedge ddr2_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    size_pop   = 1'b0;
    word_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (size_count != '0) begin
          size_pop   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = (size_q == '0) ? IDLE : COLLECT;
      end
      COLLECT: begin
        if (local_rdata_valid) begin
          word_take = 1'b1;
          if (words_left == 7'd1) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Drop the incoming word into its lane; lane 0 is the most significant.
  always_comb begin
    asm_next = asm_data;
    unique case (lane)
      2'd0: asm_next[127:96] = local_rdata;
      2'd1: asm_next[95:64]  = local_rdata;
      2'd2: asm_next[63:32]  = local_rdata;
      2'd3: asm_next[31:0]   = local_rdata;
      default: asm_next = asm_data;
    endcase
  end

  assign beat_done = (lane == 2'd3) || (words_left == 7'd1);

  // A completed beat is staged for one cycle before it enters the FIFO.
  always_ff @(posedge ddr2_clk) begin
    if (sys_rst) begin
      size_q     <= '0;
      words_left <= '0;
      lane       <= '0;
      asm_data   <= '0;
      pend_valid <= 1'b0;
      pend_beat  <= '0;
    end else begin
      pend_valid <= 1'b0;
      if (size_pop) size_q <= size_head;
      if (state == LOAD) begin
        words_left <= size_q;
        lane       <= '0;
        asm_data   <= '0;
      end
      if (word_take) begin
        words_left <= words_left - 7'd1;
        if (beat_done) begin
          pend_valid     <= 1'b1;
          pend_beat.last <= (words_left == 7'd1);
          pend_beat.data <= asm_next;
          asm_data       <= '0;
          lane           <= '0;
        end else begin
          asm_data <= asm_next;
          lane     <= lane + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- beat FIFO
  beat_t           head_beat;
  logic [BC_W-1:0] beat_count;
  logic            beat_full;
  logic            um_fire;

  assign beat_full = (beat_count == BC_W'(OUT_DEPTH));

  ddr2_out_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (OUT_DEPTH)
  ) u_beat_fifo (
    .clk     (ddr2_clk),
    .rst     (sys_rst),
    .wr_en   (pend_valid),
    .wr_data (pend_beat),
    .rd_en   (um_fire),
    .rd_data (head_beat),
    .count   (beat_count)
  );

  assign ddr2um_valid = (beat_count != '0);
  assign um_fire      = ddr2um_valid && ddr2um_ready;
  // Gated so the un-reset storage never shows on the UM bus while idle.
  assign ddr2um_data  = ddr2um_valid ? head_beat.data : '0;
  assign ddr2um_last  = ddr2um_valid && head_beat.last;

  // ---------------------------------------------------------- flow control
  // reserved = beats promised to accepted reads not yet pushed. Reads
  // rejected by a full size FIFO reserve nothing.
  logic [RES_W-1:0] reserved;
  logic [RES_W-1:0] res_add;
  logic [RES_W-1:0] res_sub;
  logic [31:0]      used;

  assign res_add = size_push ? {{(RES_W-6){1'b0}}, beats_for_size(rd_ddr2_size)} : '0;
  assign res_sub = {{(RES_W-1){1'b0}}, (pend_valid && (reserved != '0))};
  assign used    = 32'(beat_count) + 32'(reserved) + 32'(MAX_BEATS);

  always_ff @(posedge ddr2_clk) begin
    if (sys_rst) begin
      reserved     <= '0;
      read_permit  <= 1'b0;
      ddr2_out_err <= 1'b0;
    end else begin
      reserved    <= reserved + res_add - res_sub;
      // Forced low after a request so the new reservation is seen first.
      read_permit <= !rd_ddr2_size_wrreq && !size_full && (used <= 32'(OUT_DEPTH));
      if ((local_rdata_valid && (state != COLLECT)) || (pend_valid && beat_full))
        ddr2_out_err <= 1'b1;
    end
  end

`ifdef DDR2_CTRL_OUTPUT_STATS_EN
  // ---------------------------------------------------------- statistics
  logic [31:0] beats_cnt;
  logic [31:0] reads_cnt;

  always_ff @(posedge ddr2_clk) begin
    if (sys_rst) begin
      beats_cnt <= '0;
      reads_cnt <= '0;
    end else if (um_fire) begin
      beats_cnt <= beats_cnt + 32'd1;
      if (head_beat.last) reads_cnt <= reads_cnt + 32'd1;
    end
  end

  assign stat_beats = beats_cnt;
  assign stat_reads = reads_cnt;
`endif

endmodule
`default_nettype wire
